// File: rtl/invl_stats_rdr.sv
// ---------------------------------------------------------------------------
// invl_stats_rdr
//
// Consumer side of the interval stats counter bank. An interval timer fires a
// one-cycle latch_clr pulse to every counter, then the latched shadow values
// are walked through an external combinational select mux and streamed out
// as one report: a header word followed by one word per counter.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   cfg_enable     run the interval timer
//   cfg_interval   interval period in clk cycles (floored at NUM_CTR+2)
//   latch_clr      one-cycle pulse: counters latch their value and clear
//   ctr_sel        index of the latched counter presented on ctr_data
//   ctr_data       latched counter value selected by ctr_sel
//   out_valid      stream word valid
//   out_ready      downstream accept
//   out_data       stream word
//   out_sop        header (first word of report)
//   out_eop        last counter word of report
//   overrun        one-cycle pulse when an expiry had to be skipped
// ---------------------------------------------------------------------------
module invl_stats_rdr #(
  parameter  int NUM_CTR = 8,
  parameter  int SIZE    = 32,
  parameter  int TMR_W   = 32,
  localparam int SEL_W   = (NUM_CTR > 1) ? $clog2(NUM_CTR) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_enable,
  input  logic [TMR_W-1:0] cfg_interval,
  output logic             latch_clr,
  output logic [SEL_W-1:0] ctr_sel,
  input  logic [SIZE-1:0]  ctr_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic             overrun
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA
  } state_t;

  // A report needs NUM_CTR+1 accepted words plus the return to idle, so this
  // floor guarantees no skipped expiries while the consumer is always ready.
  localparam logic [TMR_W-1:0] MIN_INTERVAL = TMR_W'(NUM_CTR + 2);
  localparam logic [SEL_W-1:0] LAST_IDX     = SEL_W'(NUM_CTR - 1);
  localparam logic [7:0]       NUM_CTR_B    = 8'(NUM_CTR);

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [15:0]      seq_q, seq_d;
  logic [7:0]       skip_cnt_q, skip_cnt_d;
  logic [7:0]       hdr_skip_q, hdr_skip_d;

  logic [TMR_W-1:0] eff_interval;
  logic             expiry;
  logic             accept;
  logic [31:0]      hdr_word;

  assign eff_interval = (cfg_interval < MIN_INTERVAL) ? MIN_INTERVAL : cfg_interval;
  assign expiry       = cfg_enable && (timer_q == '0);
  assign hdr_word     = {seq_q, hdr_skip_q, NUM_CTR_B};

  // Stream outputs decode straight from registered state so they hold
  // naturally while the consumer stalls.
  always_comb begin
    out_valid = (state_q != ST_IDLE);
    out_sop   = (state_q == ST_HDR);
    out_eop   = (state_q == ST_DATA) && (idx_q == LAST_IDX);
    ctr_sel   = idx_q;
    out_data  = '0;
    case (state_q)
      ST_HDR:  out_data = SIZE'(hdr_word);
      ST_DATA: out_data = ctr_data;
      default: out_data = '0;
    endcase
  end

  assign accept = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    idx_d      = idx_q;
    seq_d      = seq_q;
    skip_cnt_d = skip_cnt_q;
    hdr_skip_d = hdr_skip_q;
    latch_clr  = 1'b0;
    overrun    = 1'b0;

    if (!cfg_enable || expiry) begin
      timer_d = eff_interval - TMR_W'(1);
    end else begin
      timer_d = timer_q - TMR_W'(1);
    end

    // An expiry during readout must not latch: the shadow registers are
    // still being read. The counters keep accumulating instead, so the next
    // report covers the merged intervals and the header records how many
    // expiries were folded in.
    if (expiry && !rst) begin
      if (state_q == ST_IDLE) begin
        latch_clr  = 1'b1;
        hdr_skip_d = skip_cnt_q;
        skip_cnt_d = '0;
        state_d    = ST_HDR;
      end else begin
        overrun = 1'b1;
        if (skip_cnt_q != 8'hFF) begin
          skip_cnt_d = skip_cnt_q + 8'd1;
        end
      end
    end

    case (state_q)
      ST_HDR: begin
        if (accept) begin
          state_d = ST_DATA;
          idx_d   = '0;
          seq_d   = seq_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + SEL_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      idx_q      <= '0;
      seq_q      <= '0;
      skip_cnt_q <= '0;
      hdr_skip_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      seq_q      <= seq_d;
      skip_cnt_q <= skip_cnt_d;
      hdr_skip_q <= hdr_skip_d;
    end
  end

endmodule
